// File: rtl/cl2_pl_pkg.sv
// Shared types for the cl2 pipelined execution unit.
// Holds the write-back entry layout used by the LSU response buffer and the bench.
`ifndef CL2_XLEN
`define CL2_XLEN 32
`endif
`ifndef CL2_REGFILE_WIDTH
`define CL2_REGFILE_WIDTH 5
`endif
`ifndef CL2_REGFILE_NUM
`define CL2_REGFILE_NUM 32
`endif

package cl2_pl_pkg;

    localparam int unsigned CL2_PL_XLEN   = `CL2_XLEN;
    localparam int unsigned CL2_PL_RF_AW  = `CL2_REGFILE_WIDTH;
    localparam int unsigned CL2_PL_RF_NUM = `CL2_REGFILE_NUM;

    typedef struct packed {
        logic [CL2_PL_RF_AW-1:0] idx;
        logic [CL2_PL_XLEN-1:0]  dat;
    } cl2_pl_wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } cl2_pl_wb_src_e;

endpackage

// File: rtl/cl2_pl_wbck_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; head data is read combinationally.
module cl2_pl_wbck_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Full when the wrap bits differ but the slot addresses coincide.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cl2_pl_exu_wbck.sv
// Write-back stage: arbitrates buffered LSU responses over ALU results into one
// registered regfile write per cycle and tracks pending loads for issue hazards.
`ifndef CL2_XLEN
`define CL2_XLEN 32
`endif
`ifndef CL2_REGFILE_WIDTH
`define CL2_REGFILE_WIDTH 5
`endif
`ifndef CL2_REGFILE_NUM
`define CL2_REGFILE_NUM 32
`endif

module cl2_pl_exu_wbck
    import cl2_pl_pkg::*;
#(
    parameter int unsigned XLEN           = `CL2_XLEN,
    parameter int unsigned RF_AW          = `CL2_REGFILE_WIDTH,
    parameter int unsigned RF_NUM         = `CL2_REGFILE_NUM,
    parameter int unsigned LSU_FIFO_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [RF_AW-1:0] alu_idx_i,
    input  logic [XLEN-1:0]  alu_dat_i,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [RF_AW-1:0] lsu_idx_i,
    input  logic [XLEN-1:0]  lsu_dat_i,
    input  logic             ld_issue_i,
    input  logic [RF_AW-1:0] ld_issue_idx_i,
    input  logic [RF_AW-1:0] rs1_idx_i,
    input  logic [RF_AW-1:0] rs2_idx_i,
    input  logic [RF_AW-1:0] rd_idx_i,
    output logic             hazard_o,
    output logic             wd_wen_o,
    output logic [RF_AW-1:0] wd_idx_o,
    output logic [XLEN-1:0]  wd_dat_o
);

    cl2_pl_wb_entry_t lsu_in;
    cl2_pl_wb_entry_t lsu_head;
    cl2_pl_wb_entry_t sel_entry;
    cl2_pl_wb_src_e   sel_src;
    logic             fifo_full, fifo_empty;
    logic             xfer;

    logic             wd_wen_q, wd_wen_d;
    logic [RF_AW-1:0] wd_idx_q;
    logic [XLEN-1:0]  wd_dat_q;
    cl2_pl_wb_src_e   wd_src_q;

    logic [RF_NUM-1:0] sb_q, sb_d;

    assign lsu_in = '{idx: lsu_idx_i, dat: lsu_dat_i};

    cl2_pl_wbck_fifo #(
        .WIDTH ($bits(cl2_pl_wb_entry_t)),
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (lsu_valid_i),
        .push_dat_i (lsu_in),
        .pop_i      (!fifo_empty),
        .pop_dat_o  (lsu_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign lsu_ready_o = !fifo_full;
    assign alu_ready_o = fifo_empty;

    // Buffered loads always win; the ALU only gets the port when the buffer is empty.
    always_comb begin
        xfer      = 1'b0;
        sel_src   = WB_SRC_ALU;
        sel_entry = '0;
        if (!fifo_empty) begin
            xfer      = 1'b1;
            sel_src   = WB_SRC_LSU;
            sel_entry = lsu_head;
        end else if (alu_valid_i) begin
            xfer      = 1'b1;
            sel_entry = '{idx: alu_idx_i, dat: alu_dat_i};
        end
    end

    assign wd_wen_d = xfer && (sel_entry.idx != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_wen_q <= 1'b0;
            wd_idx_q <= '0;
            wd_dat_q <= '0;
            wd_src_q <= WB_SRC_ALU;
            sb_q     <= '0;
        end else begin
            wd_wen_q <= wd_wen_d;
            sb_q     <= sb_d;
            if (xfer) begin
                wd_idx_q <= sel_entry.idx;
                wd_dat_q <= sel_entry.dat;
                wd_src_q <= sel_src;
            end
        end
    end

    // Pending bit clears on the same edge the load data reaches the regfile; a new issue wins.
    for (genvar gi = 0; gi < RF_NUM; gi++) begin : g_sb
        if (gi == 0) begin : g_zero
            assign sb_d[gi] = 1'b0;
        end else begin : g_bit
            logic sb_set, sb_clr;
            assign sb_set   = ld_issue_i && (ld_issue_idx_i == RF_AW'(gi));
            assign sb_clr   = wd_wen_q && (wd_src_q == WB_SRC_LSU) && (wd_idx_q == RF_AW'(gi));
            assign sb_d[gi] = sb_set || (sb_q[gi] && !sb_clr);
        end
    end

    logic rs1_nz, rs2_nz, rd_nz, sb_hit, fwd_hit;

    assign rs1_nz  = (rs1_idx_i != '0);
    assign rs2_nz  = (rs2_idx_i != '0);
    assign rd_nz   = (rd_idx_i  != '0);
    assign sb_hit  = (rs1_nz && sb_q[rs1_idx_i]) ||
                     (rs2_nz && sb_q[rs2_idx_i]) ||
                     (rd_nz  && sb_q[rd_idx_i]);
    // The regfile only sees wd_* at the next edge, so a source matching it must wait.
    assign fwd_hit = wd_wen_q && ((rs1_nz && (wd_idx_q == rs1_idx_i)) ||
                                  (rs2_nz && (wd_idx_q == rs2_idx_i)));
    assign hazard_o = sb_hit || fwd_hit;

    assign wd_wen_o = wd_wen_q;
    assign wd_idx_o = wd_idx_q;
    assign wd_dat_o = wd_dat_q;

    lsu_resp_without_pending_load_a : assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (lsu_valid_i && lsu_ready_o && (lsu_idx_i != '0)) |-> sb_q[lsu_idx_i]
    );

endmodule

// File: tb/tb_cl2_pl_exu_wbck.sv
// Bench for cl2_pl_exu_wbck: scenario tasks with inline checks plus an ordered
// write scoreboard filled when stimulus is driven and drained by a write monitor.
`ifndef CL2_XLEN
`define CL2_XLEN 32
`endif
`ifndef CL2_REGFILE_WIDTH
`define CL2_REGFILE_WIDTH 5
`endif
`ifndef CL2_REGFILE_NUM
`define CL2_REGFILE_NUM 32
`endif

module tb_cl2_pl_exu_wbck;
    import cl2_pl_pkg::*;

    localparam int unsigned XL    = `CL2_XLEN;
    localparam int unsigned AW    = `CL2_REGFILE_WIDTH;
    localparam int unsigned NR    = `CL2_REGFILE_NUM;
    localparam int unsigned DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          alu_valid_i = 1'b0;
    logic          alu_ready_o;
    logic [AW-1:0] alu_idx_i = '0;
    logic [XL-1:0] alu_dat_i = '0;
    logic          lsu_valid_i = 1'b0;
    logic          lsu_ready_o;
    logic [AW-1:0] lsu_idx_i = '0;
    logic [XL-1:0] lsu_dat_i = '0;
    logic          ld_issue_i = 1'b0;
    logic [AW-1:0] ld_issue_idx_i = '0;
    logic [AW-1:0] rs1_idx_i = '0;
    logic [AW-1:0] rs2_idx_i = '0;
    logic [AW-1:0] rd_idx_i = '0;
    logic          hazard_o;
    logic          wd_wen_o;
    logic [AW-1:0] wd_idx_o;
    logic [XL-1:0] wd_dat_o;

    int n_checks = 0;
    int n_fails  = 0;
    cl2_pl_wb_entry_t exp_q[$];

    cl2_pl_exu_wbck #(
        .XLEN(XL), .RF_AW(AW), .RF_NUM(NR), .LSU_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_idx_i(alu_idx_i), .alu_dat_i(alu_dat_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_idx_i(lsu_idx_i), .lsu_dat_i(lsu_dat_i),
        .ld_issue_i(ld_issue_i), .ld_issue_idx_i(ld_issue_idx_i),
        .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i), .rd_idx_i(rd_idx_i),
        .hazard_o(hazard_o),
        .wd_wen_o(wd_wen_o), .wd_idx_o(wd_idx_o), .wd_dat_o(wd_dat_o)
    );

    always #5 clk_i = ~clk_i;

    // Every regfile write must match the oldest outstanding expected write.
    always @(negedge clk_i) begin
        if (rst_n_i && wd_wen_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL mon_unexpected_write: got idx=%0d dat=%08h, required no write", wd_idx_o, wd_dat_o);
            end else begin
                cl2_pl_wb_entry_t e;
                e = exp_q.pop_front();
                if ({wd_idx_o, wd_dat_o} !== {e.idx, e.dat}) begin
                    n_fails++;
                    $display("FAIL mon_write_order: got idx=%0d dat=%08h, required idx=%0d dat=%08h",
                             wd_idx_o, wd_dat_o, e.idx, e.dat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rs1_idx_i = 5'd7;
        rd_idx_i  = 5'd9;
        repeat (3) step();
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o} !== '0) begin
            n_fails++;
            $display("FAIL reset_wd: got wen=%0b idx=%0d dat=%08h, required all 0", wd_wen_o, wd_idx_o, wd_dat_o);
        end
        n_checks++;
        if ({lsu_ready_o, alu_ready_o, hazard_o} !== 3'b110) begin
            n_fails++;
            $display("FAIL reset_ctrl: got lsu_rdy=%0b alu_rdy=%0b hazard=%0b, required 1 1 0",
                     lsu_ready_o, alu_ready_o, hazard_o);
        end
        rs1_idx_i = '0;
        rd_idx_i  = '0;
        rst_n_i   = 1'b1;
        step();
        step();
    endtask

    task automatic test_alu_only();
        alu_valid_i = 1'b1; alu_idx_i = 5'd5; alu_dat_i = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (alu_ready_o !== 1'b1) begin
            n_fails++; $display("FAIL alu_ready_empty: got %0b, required 1", alu_ready_o);
        end
        exp_q.push_back('{idx: 5'd5, dat: 32'hDEADBEEF});
        step();
        alu_valid_i = 1'b0;
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fails++;
            $display("FAIL alu_write: got wen=%0b idx=%0d dat=%08h, required 1 5 deadbeef", wd_wen_o, wd_idx_o, wd_dat_o);
        end
        step();
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_fails++;
            $display("FAIL alu_idle_hold: got wen=%0b idx=%0d dat=%08h, required 0 5 deadbeef", wd_wen_o, wd_idx_o, wd_dat_o);
        end
    endtask

    task automatic test_x0_suppress();
        alu_valid_i = 1'b1; alu_idx_i = 5'd0; alu_dat_i = 32'h00001234;
        #1;
        n_checks++;
        if (alu_ready_o !== 1'b1) begin
            n_fails++; $display("FAIL x0_handshake: got alu_ready=%0b, required 1", alu_ready_o);
        end
        step();
        alu_valid_i = 1'b0;
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o} !== {1'b0, 5'd0, 32'h00001234}) begin
            n_fails++;
            $display("FAIL x0_suppress: got wen=%0b idx=%0d dat=%08h, required 0 0 00001234", wd_wen_o, wd_idx_o, wd_dat_o);
        end
        step();
    endtask

    task automatic test_collision();
        ld_issue_i = 1'b1; ld_issue_idx_i = 5'd3;
        step();
        ld_issue_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_idx_i = 5'd3; lsu_dat_i = 32'hA5A50003;
        alu_valid_i = 1'b1; alu_idx_i = 5'd4; alu_dat_i = 32'h00000044;
        exp_q.push_back('{idx: 5'd4, dat: 32'h00000044});
        exp_q.push_back('{idx: 5'd3, dat: 32'hA5A50003});
        exp_q.push_back('{idx: 5'd4, dat: 32'h00000045});
        step();
        lsu_valid_i = 1'b0;
        alu_dat_i   = 32'h00000045;
        n_checks++;
        if ({wd_wen_o, wd_idx_o, alu_ready_o} !== {1'b1, 5'd4, 1'b0}) begin
            n_fails++;
            $display("FAIL coll_alu_stall: got wen=%0b idx=%0d alu_ready=%0b, required 1 4 0", wd_wen_o, wd_idx_o, alu_ready_o);
        end
        step();
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o, alu_ready_o} !== {1'b1, 5'd3, 32'hA5A50003, 1'b1}) begin
            n_fails++;
            $display("FAIL coll_lsu_write: got wen=%0b idx=%0d dat=%08h alu_ready=%0b, required 1 3 a5a50003 1",
                     wd_wen_o, wd_idx_o, wd_dat_o, alu_ready_o);
        end
        step();
        alu_valid_i = 1'b0;
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o} !== {1'b1, 5'd4, 32'h00000045}) begin
            n_fails++;
            $display("FAIL coll_alu_late: got wen=%0b idx=%0d dat=%08h, required 1 4 00000045", wd_wen_o, wd_idx_o, wd_dat_o);
        end
        step();
        n_checks++;
        if (wd_wen_o !== 1'b0) begin
            n_fails++; $display("FAIL coll_quiet: got wen=%0b, required 0", wd_wen_o);
        end
    endtask

    task automatic test_scoreboard();
        ld_issue_i = 1'b1; ld_issue_idx_i = 5'd7;
        #1;
        n_checks++;
        if (hazard_o !== 1'b0) begin
            n_fails++; $display("FAIL sb_before_issue: got hazard=%0b, required 0", hazard_o);
        end
        step();
        ld_issue_i = 1'b0;
        rs1_idx_i = 5'd7; #1;
        n_checks++;
        if (hazard_o !== 1'b1) begin n_fails++; $display("FAIL sb_rs1: got hazard=%0b, required 1", hazard_o); end
        rs1_idx_i = 5'd0; #1;
        n_checks++;
        if (hazard_o !== 1'b0) begin n_fails++; $display("FAIL sb_rs_zero: got hazard=%0b, required 0", hazard_o); end
        rd_idx_i = 5'd7; #1;
        n_checks++;
        if (hazard_o !== 1'b1) begin n_fails++; $display("FAIL sb_rd: got hazard=%0b, required 1", hazard_o); end
        rd_idx_i = 5'd0; rs2_idx_i = 5'd7; #1;
        n_checks++;
        if (hazard_o !== 1'b1) begin n_fails++; $display("FAIL sb_rs2: got hazard=%0b, required 1", hazard_o); end
        rs2_idx_i = 5'd0; rs1_idx_i = 5'd7;
        step();
        step();
        n_checks++;
        if (hazard_o !== 1'b1) begin n_fails++; $display("FAIL sb_persist: got hazard=%0b, required 1", hazard_o); end
        lsu_valid_i = 1'b1; lsu_idx_i = 5'd7; lsu_dat_i = 32'h77770007;
        exp_q.push_back('{idx: 5'd7, dat: 32'h77770007});
        step();
        lsu_valid_i = 1'b0;
        n_checks++;
        if ({hazard_o, wd_wen_o} !== 2'b10) begin
            n_fails++; $display("FAIL sb_in_fifo: got hazard=%0b wen=%0b, required 1 0", hazard_o, wd_wen_o);
        end
        step();
        n_checks++;
        if ({hazard_o, wd_wen_o, wd_idx_o} !== {1'b1, 1'b1, 5'd7}) begin
            n_fails++; $display("FAIL sb_landing: got hazard=%0b wen=%0b idx=%0d, required 1 1 7", hazard_o, wd_wen_o, wd_idx_o);
        end
        step();
        n_checks++;
        if (hazard_o !== 1'b0) begin n_fails++; $display("FAIL sb_cleared: got hazard=%0b, required 0", hazard_o); end
        rs1_idx_i = 5'd0;
        alu_valid_i = 1'b1; alu_idx_i = 5'd6; alu_dat_i = 32'h00000066;
        exp_q.push_back('{idx: 5'd6, dat: 32'h00000066});
        step();
        alu_valid_i = 1'b0;
        rs2_idx_i = 5'd6; #1;
        n_checks++;
        if (hazard_o !== 1'b1) begin n_fails++; $display("FAIL fwd_rs2: got hazard=%0b, required 1", hazard_o); end
        rs2_idx_i = 5'd0; rd_idx_i = 5'd6; #1;
        n_checks++;
        if (hazard_o !== 1'b0) begin n_fails++; $display("FAIL fwd_rd_ignored: got hazard=%0b, required 0", hazard_o); end
        rd_idx_i = 5'd0;
        step();
        rs2_idx_i = 5'd6; #1;
        n_checks++;
        if (hazard_o !== 1'b0) begin n_fails++; $display("FAIL fwd_done: got hazard=%0b, required 0", hazard_o); end
        rs2_idx_i = 5'd0;
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        for (int i = 0; i < 3; i++) begin
            ld_issue_i = 1'b1; ld_issue_idx_i = AW'(10 + i);
            step();
        end
        ld_issue_i = 1'b0;
        // Buffer occupancy model: one push per cycle at most, head drains every cycle.
        for (int c = 0; c < 7; c++) begin
            logic push;
            logic exp_wen;
            exp_wen = (c >= 2) && (c <= 4);
            n_checks++;
            if (wd_wen_o !== exp_wen || (exp_wen && wd_idx_o !== AW'(10 + c - 2))) begin
                n_fails++;
                $display("FAIL b2b_lsu_write c=%0d: got wen=%0b idx=%0d, required wen=%0b idx=%0d",
                         c, wd_wen_o, wd_idx_o, exp_wen, 10 + c - 2);
            end
            lsu_valid_i = (c < 3);
            lsu_idx_i   = AW'(10 + c);
            lsu_dat_i   = 32'hB0B00000 + XL'(c);
            #1;
            n_checks++;
            if (lsu_ready_o !== (cnt < DEPTH)) begin
                n_fails++;
                $display("FAIL b2b_lsu_ready c=%0d: got %0b, required %0b (held=%0d)", c, lsu_ready_o, cnt < DEPTH, cnt);
            end
            push = lsu_valid_i && (cnt < DEPTH);
            if (push) exp_q.push_back('{idx: lsu_idx_i, dat: lsu_dat_i});
            cnt = cnt + (push ? 1 : 0) - ((cnt > 0) ? 1 : 0);
            step();
        end
        lsu_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            logic exp_wen;
            exp_wen = (c >= 1);
            n_checks++;
            if (wd_wen_o !== exp_wen || (exp_wen && wd_idx_o !== AW'(20 + c - 1))) begin
                n_fails++;
                $display("FAIL b2b_alu_write c=%0d: got wen=%0b idx=%0d, required wen=%0b idx=%0d",
                         c, wd_wen_o, wd_idx_o, exp_wen, 20 + c - 1);
            end
            alu_valid_i = (c < 4);
            alu_idx_i   = AW'(20 + c);
            alu_dat_i   = 32'hC0DE0000 + XL'(c);
            if (alu_valid_i) exp_q.push_back('{idx: alu_idx_i, dat: alu_dat_i});
            step();
        end
        alu_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_midflight();
        ld_issue_i = 1'b1; ld_issue_idx_i = 5'd9;
        step();
        ld_issue_idx_i = 5'd8;
        step();
        ld_issue_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_idx_i = 5'd8; lsu_dat_i = 32'hDEAD0008;
        step();
        lsu_valid_i = 1'b0;
        rs1_idx_i = 5'd9; rs2_idx_i = 5'd8; #1;
        n_checks++;
        if ({hazard_o, alu_ready_o} !== 2'b10) begin
            n_fails++; $display("FAIL pre_reset_state: got hazard=%0b alu_ready=%0b, required 1 0", hazard_o, alu_ready_o);
        end
        rst_n_i = 1'b0; #1;
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o, lsu_ready_o, alu_ready_o, hazard_o} !==
            {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL midflight_reset: got wen=%0b idx=%0d dat=%08h lsu_rdy=%0b alu_rdy=%0b hazard=%0b, required 0 0 0 1 1 0",
                     wd_wen_o, wd_idx_o, wd_dat_o, lsu_ready_o, alu_ready_o, hazard_o);
        end
        step();
        step();
        rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if ({wd_wen_o, hazard_o, alu_ready_o} !== 3'b001) begin
                n_fails++;
                $display("FAIL post_reset_quiet c=%0d: got wen=%0b hazard=%0b alu_ready=%0b, required 0 0 1",
                         c, wd_wen_o, hazard_o, alu_ready_o);
            end
        end
        rs1_idx_i = '0; rs2_idx_i = '0;
        alu_valid_i = 1'b1; alu_idx_i = 5'd2; alu_dat_i = 32'h00002222;
        exp_q.push_back('{idx: 5'd2, dat: 32'h00002222});
        step();
        alu_valid_i = 1'b0;
        n_checks++;
        if ({wd_wen_o, wd_idx_o, wd_dat_o} !== {1'b1, 5'd2, 32'h00002222}) begin
            n_fails++;
            $display("FAIL post_reset_write: got wen=%0b idx=%0d dat=%08h, required 1 2 00002222", wd_wen_o, wd_idx_o, wd_dat_o);
        end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_x0_suppress();
        test_collision();
        test_scoreboard();
        test_back_to_back();
        test_reset_midflight();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drained: got %0d outstanding writes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
